// File: rtl/riscv_pkg.sv
// Shared RV32M encodings and M-unit FSM states for the execute stage.
package riscv_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   localparam int MD_ITERS = 32;

   // MUL low bits are sign-agnostic, so it shares the signed path with MULH.
   function automatic logic md_a_signed(input logic [2:0] f3);
      return f3 inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   endfunction

   function automatic logic md_b_signed(input logic [2:0] f3);
      return f3 inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
   endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative unsigned core: 32-step shift-add multiply or restoring divide on a 64-bit accumulator.
module md_iter_core
   import riscv_pkg::*;
#(
   parameter int D_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic                   is_div_i,
   input  logic [D_WIDTH-1:0]     op_a_i,
   input  logic [D_WIDTH-1:0]     op_b_i,
   output logic                   done_o,
   output logic [2*D_WIDTH-1:0]   acc_o
);

   localparam int CNT_W = $clog2(MD_ITERS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITERS - 1);

   logic                 run_q, run_d;
   logic                 div_q, div_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [D_WIDTH-1:0]   opnd_q, opnd_d;
   logic [2*D_WIDTH-1:0] acc_q, acc_d;
   logic [D_WIDTH:0]     sum;
   logic [D_WIDTH:0]     rem_sh;
   logic [D_WIDTH:0]     diff;

   // Accumulator starts as {0, A}; B is the multiplicand or the divisor.
   always_comb begin
      run_d  = run_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      opnd_d = opnd_q;
      acc_d  = acc_q;
      sum    = {1'b0, acc_q[2*D_WIDTH-1:D_WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(D_WIDTH+1){1'b0}});
      rem_sh = acc_q[2*D_WIDTH-1:D_WIDTH-1];
      diff   = rem_sh - {1'b0, opnd_q};
      if (abort_i) begin
         run_d = 1'b0;
      end else if (start_i) begin
         run_d  = 1'b1;
         div_d  = is_div_i;
         cnt_d  = '0;
         opnd_d = op_b_i;
         acc_d  = {{D_WIDTH{1'b0}}, op_a_i};
      end else if (run_q) begin
         if (div_q) begin
            acc_d = diff[D_WIDTH] ? {rem_sh[D_WIDTH-1:0], acc_q[D_WIDTH-2:0], 1'b0}
                                  : {diff[D_WIDTH-1:0], acc_q[D_WIDTH-2:0], 1'b1};
         end else begin
            acc_d = {sum, acc_q[D_WIDTH-1:1]};
         end
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_LAST) begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q  <= 1'b0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
         opnd_q <= '0;
         acc_q  <= '0;
      end else begin
         run_q  <= run_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         opnd_q <= opnd_d;
         acc_q  <= acc_d;
      end
   end

   assign done_o = run_q & (cnt_q == CNT_LAST);
   assign acc_o  = acc_q;

endmodule

// File: rtl/execute_muldiv_stage.sv
// E-stage back end: E->M register plus multi-cycle RV32M unit with front-end stall.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplies; divides stay iterative.
module execute_muldiv_stage
   import riscv_pkg::*;
#(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               FlushE_i,
   input  logic               RegWriteE_i,
   input  logic               MemWriteE_i,
   input  logic               a_typeE_i,
   input  logic               MdE_i,
   input  logic [1:0]         ResultSrcE_i,
   input  logic [2:0]         funct3E_i,
   input  logic [A_WIDTH-1:0] RdE_i,
   input  logic [D_WIDTH-1:0] SrcAE_i,
   input  logic [D_WIDTH-1:0] SrcBE_i,
   input  logic [D_WIDTH-1:0] ALUResultE_i,
   input  logic [D_WIDTH-1:0] WriteDataE_i,
   input  logic [D_WIDTH-1:0] PCPlus4E_i,
   output logic               StallE_o,
   output logic               BusyE_o,
   output logic               RegWriteM,
   output logic               MemWriteM,
   output logic               a_typeM,
   output logic [1:0]         ResultSrcM,
   output logic [A_WIDTH-1:0] RdM,
   output logic [D_WIDTH-1:0] ALUResultM,
   output logic [D_WIDTH-1:0] WriteDataM,
   output logic [D_WIDTH-1:0] PCPlus4M
);

   localparam logic [1:0] ST_IDLE = MD_IDLE;
   localparam logic [1:0] ST_BUSY = MD_BUSY;
   localparam logic [1:0] ST_DONE = MD_DONE;
   localparam logic [D_WIDTH-1:0] INT_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};

   logic [1:0]           state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic                 a_neg_q, a_neg_d, b_neg_q, b_neg_d;
   logic                 a_neg, b_neg, is_div, div_by_zero, div_ovf, special;
   logic                 fast_hit, issue, core_done, bubble;
   logic [D_WIDTH-1:0]   a_abs, b_abs, special_res, fast_res, md_res, quot, rem;
   logic [2*D_WIDTH-1:0] acc, prod;

   logic                 reg_write_m_q, reg_write_m_d, mem_write_m_q, mem_write_m_d;
   logic                 a_type_m_q, a_type_m_d;
   logic [1:0]           result_src_m_q, result_src_m_d;
   logic [A_WIDTH-1:0]   rd_m_q, rd_m_d;
   logic [D_WIDTH-1:0]   alu_result_m_q, alu_result_m_d, write_data_m_q, write_data_m_d;
   logic [D_WIDTH-1:0]   pc_plus4_m_q, pc_plus4_m_d;

   always_comb begin
      a_neg       = md_a_signed(funct3E_i) & SrcAE_i[D_WIDTH-1];
      b_neg       = md_b_signed(funct3E_i) & SrcBE_i[D_WIDTH-1];
      a_abs       = a_neg ? -SrcAE_i : SrcAE_i;
      b_abs       = b_neg ? -SrcBE_i : SrcBE_i;
      is_div      = funct3E_i[2];
      div_by_zero = (SrcBE_i == '0);
      div_ovf     = ~funct3E_i[0] & (SrcAE_i == INT_MIN) & (SrcBE_i == '1);
      special     = MdE_i & is_div & (div_by_zero | div_ovf);
      if (funct3E_i[1]) begin
         special_res = div_by_zero ? SrcAE_i : '0;
      end else begin
         special_res = div_by_zero ? '1 : INT_MIN;
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*D_WIDTH-1:0] fast_a, fast_b, fast_prod;

   // Sign-extended operands give a product whose low 64 bits are exact for every MUL variant.
   always_comb begin
      fast_a    = {{D_WIDTH{a_neg}}, SrcAE_i};
      fast_b    = {{D_WIDTH{b_neg}}, SrcBE_i};
      fast_prod = fast_a * fast_b;
      fast_hit  = MdE_i & ~is_div;
      fast_res  = (funct3E_i == MD_MUL) ? fast_prod[D_WIDTH-1:0] : fast_prod[2*D_WIDTH-1:D_WIDTH];
   end
`else
   assign fast_hit = 1'b0;
   assign fast_res = '0;
`endif

   assign issue    = ~rst & (state_q == ST_IDLE) & MdE_i & ~FlushE_i & ~special & ~fast_hit;
   assign StallE_o = ~rst & (issue | ((state_q == ST_BUSY) & ~FlushE_i));
   assign BusyE_o  = (state_q != ST_IDLE);
   assign bubble   = StallE_o | FlushE_i;

   md_iter_core #(
      .D_WIDTH (D_WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .start_i  (issue),
      .abort_i  (FlushE_i),
      .is_div_i (is_div),
      .op_a_i   (a_abs),
      .op_b_i   (b_abs),
      .done_o   (core_done),
      .acc_o    (acc)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_neg_d = a_neg_q;
      b_neg_d = b_neg_q;
      case (state_q)
         ST_IDLE: begin
            if (issue) begin
               state_d = ST_BUSY;
               op_d    = funct3E_i;
               a_neg_d = a_neg;
               b_neg_d = b_neg;
            end
         end
         ST_BUSY: begin
            if (FlushE_i) begin
               state_d = ST_IDLE;
            end else if (core_done) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The core works on magnitudes; quotient/product take the XOR of signs, remainder the dividend's.
   always_comb begin
      prod = (a_neg_q ^ b_neg_q) ? -acc : acc;
      quot = (a_neg_q ^ b_neg_q) ? -acc[D_WIDTH-1:0] : acc[D_WIDTH-1:0];
      rem  = a_neg_q ? -acc[2*D_WIDTH-1:D_WIDTH] : acc[2*D_WIDTH-1:D_WIDTH];
      if (op_q[2]) begin
         md_res = op_q[1] ? rem : quot;
      end else begin
         md_res = (op_q == MD_MUL) ? prod[D_WIDTH-1:0] : prod[2*D_WIDTH-1:D_WIDTH];
      end
   end

   always_comb begin
      reg_write_m_d  = reg_write_m_q;
      mem_write_m_d  = mem_write_m_q;
      a_type_m_d     = a_type_m_q;
      result_src_m_d = result_src_m_q;
      rd_m_d         = rd_m_q;
      alu_result_m_d = alu_result_m_q;
      write_data_m_d = write_data_m_q;
      pc_plus4_m_d   = pc_plus4_m_q;
      if (bubble) begin
         reg_write_m_d = 1'b0;
         mem_write_m_d = 1'b0;
      end else begin
         reg_write_m_d  = RegWriteE_i;
         mem_write_m_d  = MemWriteE_i;
         a_type_m_d     = a_typeE_i;
         result_src_m_d = ResultSrcE_i;
         rd_m_d         = RdE_i;
         write_data_m_d = WriteDataE_i;
         pc_plus4_m_d   = PCPlus4E_i;
         if (state_q == ST_DONE) begin
            alu_result_m_d = md_res;
         end else if (special) begin
            alu_result_m_d = special_res;
         end else if (fast_hit) begin
            alu_result_m_d = fast_res;
         end else begin
            alu_result_m_d = ALUResultE_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         op_q           <= '0;
         a_neg_q        <= 1'b0;
         b_neg_q        <= 1'b0;
         reg_write_m_q  <= 1'b0;
         mem_write_m_q  <= 1'b0;
         a_type_m_q     <= 1'b0;
         result_src_m_q <= '0;
         rd_m_q         <= '0;
         alu_result_m_q <= '0;
         write_data_m_q <= '0;
         pc_plus4_m_q   <= '0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         a_neg_q        <= a_neg_d;
         b_neg_q        <= b_neg_d;
         reg_write_m_q  <= reg_write_m_d;
         mem_write_m_q  <= mem_write_m_d;
         a_type_m_q     <= a_type_m_d;
         result_src_m_q <= result_src_m_d;
         rd_m_q         <= rd_m_d;
         alu_result_m_q <= alu_result_m_d;
         write_data_m_q <= write_data_m_d;
         pc_plus4_m_q   <= pc_plus4_m_d;
      end
   end

   assign RegWriteM  = reg_write_m_q;
   assign MemWriteM  = mem_write_m_q;
   assign a_typeM    = a_type_m_q;
   assign ResultSrcM = result_src_m_q;
   assign RdM        = rd_m_q;
   assign ALUResultM = alu_result_m_q;
   assign WriteDataM = write_data_m_q;
   assign PCPlus4M   = pc_plus4_m_q;

endmodule

// File: tb/tb_execute_muldiv_stage.sv
// Bench for execute_muldiv_stage: arithmetic reference model checked every cycle plus directed literals.
module tb_execute_muldiv_stage;

`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
   localparam int MUL_STALLS = 0;
`else
   localparam bit FAST = 1'b0;
   localparam int MUL_STALLS = 33;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        FlushE_i, RegWriteE_i, MemWriteE_i, a_typeE_i, MdE_i;
   logic [1:0]  ResultSrcE_i;
   logic [2:0]  funct3E_i;
   logic [4:0]  RdE_i;
   logic [31:0] SrcAE_i, SrcBE_i, ALUResultE_i, WriteDataE_i, PCPlus4E_i;
   logic        StallE_o, BusyE_o, RegWriteM, MemWriteM, a_typeM;
   logic [1:0]  ResultSrcM;
   logic [4:0]  RdM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

   int          vectors = 0;
   int          miscompares = 0;
   int          rw_pulses = 0;
   bit          pulse_en = 1'b0;
   logic [31:0] pc_cnt = 32'h100;
   int          stalls;

   always #5 clk = ~clk;

   execute_muldiv_stage dut (
      .clk          (clk),
      .rst          (rst),
      .FlushE_i     (FlushE_i),
      .RegWriteE_i  (RegWriteE_i),
      .MemWriteE_i  (MemWriteE_i),
      .a_typeE_i    (a_typeE_i),
      .MdE_i        (MdE_i),
      .ResultSrcE_i (ResultSrcE_i),
      .funct3E_i    (funct3E_i),
      .RdE_i        (RdE_i),
      .SrcAE_i      (SrcAE_i),
      .SrcBE_i      (SrcBE_i),
      .ALUResultE_i (ALUResultE_i),
      .WriteDataE_i (WriteDataE_i),
      .PCPlus4E_i   (PCPlus4E_i),
      .StallE_o     (StallE_o),
      .BusyE_o      (BusyE_o),
      .RegWriteM    (RegWriteM),
      .MemWriteM    (MemWriteM),
      .a_typeM      (a_typeM),
      .ResultSrcM   (ResultSrcM),
      .RdM          (RdM),
      .ALUResultM   (ALUResultM),
      .WriteDataM   (WriteDataM),
      .PCPlus4M     (PCPlus4M)
   );

   // Architectural result of an RV32M op, from 64-bit integer arithmetic.
   function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sp;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f3)
         3'd0: begin up = ua * ub; return up[31:0]; end
         3'd1: begin sp = sa * sb; return sp[63:32]; end
         3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            sp = sa / sb;
            return sp[31:0];
         end
         3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            sp = sa % sb;
            return sp[31:0];
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
   endfunction

   function automatic bit is_iter(input logic [2:0] f3);
      return !FAST || f3[2];
   endfunction

   // Reference model: expected M register contents and cycles left on an in-flight M op.
   bit          model_valid = 1'b0;
   bit          in_flight;
   int          left;
   logic [2:0]  sv_f3;
   logic [31:0] sv_a, sv_b;
   logic        m_rw, m_mw, m_at;
   logic [1:0]  m_rs;
   logic [4:0]  m_rd;
   logic [31:0] m_alu, m_wd, m_pc;

   always @(posedge clk) begin
      if (rst) begin
         model_valid <= 1'b1;
         in_flight <= 1'b0;
         left <= 0;
         m_rw <= 1'b0; m_mw <= 1'b0; m_at <= 1'b0; m_rs <= '0; m_rd <= '0;
         m_alu <= '0; m_wd <= '0; m_pc <= '0;
      end else if ((in_flight && (FlushE_i || left > 0)) || (!in_flight && FlushE_i) ||
                   (!in_flight && MdE_i && is_iter(funct3E_i) && !is_special(funct3E_i, SrcAE_i, SrcBE_i))) begin
         m_rw <= 1'b0;
         m_mw <= 1'b0;
         if (in_flight && FlushE_i) begin
            in_flight <= 1'b0;
         end else if (in_flight) begin
            left <= left - 1;
         end else if (!FlushE_i) begin
            in_flight <= 1'b1;
            left <= 32;
            sv_f3 <= funct3E_i;
            sv_a <= SrcAE_i;
            sv_b <= SrcBE_i;
         end
      end else begin
         m_rw <= RegWriteE_i; m_mw <= MemWriteE_i; m_at <= a_typeE_i; m_rs <= ResultSrcE_i;
         m_rd <= RdE_i; m_wd <= WriteDataE_i; m_pc <= PCPlus4E_i;
         if (in_flight) begin
            m_alu <= md_ref(sv_f3, sv_a, sv_b);
            in_flight <= 1'b0;
         end else begin
            m_alu <= MdE_i ? md_ref(funct3E_i, SrcAE_i, SrcBE_i) : ALUResultE_i;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_valid) begin
         logic exp_stall;
         exp_stall = !rst && !FlushE_i &&
                     (in_flight ? (left > 0)
                                : (MdE_i && is_iter(funct3E_i) && !is_special(funct3E_i, SrcAE_i, SrcBE_i)));
         checkOutput("StallE_o",   32'(StallE_o),   32'(exp_stall));
         checkOutput("BusyE_o",    32'(BusyE_o),    32'(in_flight));
         checkOutput("RegWriteM",  32'(RegWriteM),  32'(m_rw));
         checkOutput("MemWriteM",  32'(MemWriteM),  32'(m_mw));
         checkOutput("a_typeM",    32'(a_typeM),    32'(m_at));
         checkOutput("ResultSrcM", 32'(ResultSrcM), 32'(m_rs));
         checkOutput("RdM",        32'(RdM),        32'(m_rd));
         checkOutput("ALUResultM", ALUResultM,      m_alu);
         checkOutput("WriteDataM", WriteDataM,      m_wd);
         checkOutput("PCPlus4M",   PCPlus4M,        m_pc);
      end
   end

   always @(negedge clk) begin
      if (pulse_en && RegWriteM) rw_pulses++;
   end

   task automatic driveE(input logic md, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] alu, input logic [4:0] rd, input logic rw, input logic mw);
      MdE_i = md;
      funct3E_i = f3;
      SrcAE_i = a;
      SrcBE_i = b;
      ALUResultE_i = alu;
      RdE_i = rd;
      RegWriteE_i = rw;
      MemWriteE_i = mw;
      a_typeE_i = rd[0];
      ResultSrcE_i = rd[2:1];
      WriteDataE_i = a ^ b;
      PCPlus4E_i = pc_cnt;
      pc_cnt = pc_cnt + 32'd4;
   endtask

   // Holds the E instruction while the stage stalls, like the hazard unit would; returns stall count.
   task automatic applyStimulus(input logic md, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] alu, input logic [4:0] rd, input logic rw, input logic mw,
                                output int n_stall);
      bit done;
      driveE(md, f3, a, b, alu, rd, rw, mw);
      n_stall = 0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (StallE_o) n_stall++;
         else done = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL stall_timeout: got stall still high after 40 cycles, expected release");
      end
   endtask

   task automatic nop();
      driveE(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 100us");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1;
      FlushE_i = 1'b0;
      driveE(1'b1, 3'd4, 32'd9, 32'd3, 32'd1, 5'd1, 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_alu", ALUResultM, 32'd0);
      checkOutput("reset_regwrite", 32'(RegWriteM), 32'd0);
      checkOutput("reset_stall", 32'(StallE_o), 32'd0);
      checkOutput("reset_busy", 32'(BusyE_o), 32'd0);
      rst = 1'b0;
      nop();
      @(posedge clk); #1;

      $display("[TB] test 1: MUL 7 x -3");
      rw_pulses = 0;
      pulse_en = 1'b1;
      applyStimulus(1'b1, 3'd0, 32'd7, 32'hFFFFFFFD, 32'd0, 5'd10, 1'b1, 1'b0, stalls);
      checkOutput("t1_mul_result", ALUResultM, 32'hFFFFFFEB);
      checkOutput("t1_mul_stalls", 32'(stalls), 32'(MUL_STALLS));
      checkOutput("t1_mul_rd", 32'(RdM), 32'd10);
      nop();
      repeat (2) @(posedge clk);
      #1;
      pulse_en = 1'b0;
      checkOutput("t1_regwrite_pulses", 32'(rw_pulses), 32'd1);

      $display("[TB] test 2: MULHU / MULH / MULHSU");
      applyStimulus(1'b1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 5'd11, 1'b1, 1'b0, stalls);
      checkOutput("t2_mulhu", ALUResultM, 32'hFFFFFFFE);
      checkOutput("t2_mulhu_stalls", 32'(stalls), 32'(MUL_STALLS));
      applyStimulus(1'b1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 5'd12, 1'b1, 1'b0, stalls);
      checkOutput("t2_mulh", ALUResultM, 32'h00000000);
      applyStimulus(1'b1, 3'd2, 32'hFFFFFFFF, 32'd2, 32'd0, 5'd13, 1'b1, 1'b0, stalls);
      checkOutput("t2_mulhsu", ALUResultM, 32'hFFFFFFFF);

      $display("[TB] test 3: signed overflow");
      applyStimulus(1'b1, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'd0, 5'd14, 1'b1, 1'b0, stalls);
      checkOutput("t3_div_ovf", ALUResultM, 32'h80000000);
      checkOutput("t3_div_ovf_stalls", 32'(stalls), 32'd0);
      applyStimulus(1'b1, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 5'd15, 1'b1, 1'b0, stalls);
      checkOutput("t3_rem_ovf", ALUResultM, 32'd0);

      $display("[TB] test 4: divide by zero and negative dividend");
      applyStimulus(1'b1, 3'd5, 32'd100, 32'd0, 32'd0, 5'd16, 1'b1, 1'b0, stalls);
      checkOutput("t4_divu_zero", ALUResultM, 32'hFFFFFFFF);
      checkOutput("t4_divu_zero_stalls", 32'(stalls), 32'd0);
      applyStimulus(1'b1, 3'd7, 32'd100, 32'd0, 32'd0, 5'd17, 1'b1, 1'b0, stalls);
      checkOutput("t4_remu_zero", ALUResultM, 32'd100);
      applyStimulus(1'b1, 3'd4, 32'hFFFFFFF9, 32'd2, 32'd0, 5'd18, 1'b1, 1'b0, stalls);
      checkOutput("t4_div_neg", ALUResultM, 32'hFFFFFFFD);
      checkOutput("t4_div_neg_stalls", 32'(stalls), 32'd33);
      applyStimulus(1'b1, 3'd6, 32'hFFFFFFF9, 32'd2, 32'd0, 5'd19, 1'b1, 1'b0, stalls);
      checkOutput("t4_rem_neg", ALUResultM, 32'hFFFFFFFF);
      applyStimulus(1'b1, 3'd5, 32'd1000, 32'd7, 32'd0, 5'd20, 1'b1, 1'b0, stalls);
      checkOutput("t4_divu", ALUResultM, 32'd142);
      applyStimulus(1'b1, 3'd7, 32'd1000, 32'd7, 32'd0, 5'd21, 1'b1, 1'b0, stalls);
      checkOutput("t4_remu", ALUResultM, 32'd6);
      applyStimulus(1'b0, 3'd0, 32'd1, 32'd2, 32'h12345678, 5'd22, 1'b0, 1'b1, stalls);
      checkOutput("t4_store_alu", ALUResultM, 32'h12345678);
      checkOutput("t4_store_memwrite", 32'(MemWriteM), 32'd1);
      checkOutput("t4_store_stalls", 32'(stalls), 32'd0);

      $display("[TB] test 5: flush in BUSY cycle 10 and flush at issue");
      rw_pulses = 0;
      pulse_en = 1'b1;
      driveE(1'b1, 3'd5, 32'd1000, 32'd7, 32'd0, 5'd23, 1'b1, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      FlushE_i = 1'b1;
      @(negedge clk);
      checkOutput("t5_flush_stall", 32'(StallE_o), 32'd0);
      @(posedge clk); #1;
      FlushE_i = 1'b0;
      nop();
      checkOutput("t5_flush_busy", 32'(BusyE_o), 32'd0);
      FlushE_i = 1'b1;
      driveE(1'b1, 3'd4, 32'd1000, 32'd7, 32'd0, 5'd24, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t5_issue_flush_stall", 32'(StallE_o), 32'd0);
      @(posedge clk); #1;
      FlushE_i = 1'b0;
      nop();
      checkOutput("t5_issue_flush_busy", 32'(BusyE_o), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      pulse_en = 1'b0;
      checkOutput("t5_flush_regwrite_pulses", 32'(rw_pulses), 32'd0);

      $display("[TB] test 6: reset mid-BUSY");
      driveE(1'b1, 3'd5, 32'hFFFFFFFF, 32'd3, 32'd0, 5'd7, 1'b1, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      driveE(1'b0, 3'd0, 32'd2, 32'd3, 32'd5, 5'd3, 1'b1, 1'b0);
      checkOutput("t6_rst_alu", ALUResultM, 32'd0);
      checkOutput("t6_rst_regwrite", 32'(RegWriteM), 32'd0);
      checkOutput("t6_rst_busy", 32'(BusyE_o), 32'd0);
      checkOutput("t6_rst_pc", PCPlus4M, 32'd0);
      @(posedge clk); #1;
      checkOutput("t6_add_alu", ALUResultM, 32'd5);
      checkOutput("t6_add_regwrite", 32'(RegWriteM), 32'd1);
      checkOutput("t6_add_rd", 32'(RdM), 32'd3);
      nop();
      repeat (2) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
